// File: rtl/ring_code_monitor_pkg.sv
// Shared types and helpers for the one-hot ring code monitor.
// Helpers work on zero-extended codes so any ring width up to MAX_W can use them.
package ring_pkg;

  typedef enum logic [1:0] {
    HUNT,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam int RING_WIDTH = 3;
  localparam int IDX_W      = $clog2(RING_WIDTH);
  localparam int MAX_W      = 32;

  function automatic logic is_onehot(input logic [MAX_W-1:0] code);
    return (code != '0) && ((code & (code - MAX_W'(1))) == '0);
  endfunction

  // Rotate left within the low w bits; bits above w come back as zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] code,
                                            input int unsigned w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return ((code << 1) | (code >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/ring_code_monitor_if.sv
// Sample input and status outputs of the ring code monitor.
// The master drives the sampled code, the slave (monitor) drives everything else.
interface ring_code_monitor_if #(
  parameter int WIDTH     = 3,
  parameter int ERR_CNT_W = 8
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0]     Ring_in;
  logic                 Ring_valid;
  logic [IW-1:0]        Index_out;
  logic                 Index_valid;
  logic                 Locked;
  logic                 Wrap_pulse;
  logic                 Code_err;
  logic                 Seq_err;
  logic [ERR_CNT_W-1:0] Err_count;

  modport master (
    output Ring_in, Ring_valid,
    input  Index_out, Index_valid, Locked, Wrap_pulse, Code_err, Seq_err, Err_count
  );

  modport slave (
    input  Ring_in, Ring_valid,
    output Index_out, Index_valid, Locked, Wrap_pulse, Code_err, Seq_err, Err_count
  );
endinterface

// File: rtl/ring_code_monitor_decode.sv
// Combinational one-hot decoder: legality flag plus bit position of the set bit.
// For illegal codes the index is don't-care and is never registered.
module ring_onehot_decode
  import ring_pkg::*;
#(
  parameter  int WIDTH = RING_WIDTH,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IW-1:0]    index
);

  always_comb begin
    legal = is_onehot(MAX_W'(code));
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (code[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/ring_code_monitor.sv
// Receive-side checker for a rotate-left one-hot ring code: decodes, locks onto
// the rotation, and flags/counts illegal codes and out-of-order samples.
module ring_code_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH     = RING_WIDTH,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  ring_code_monitor_if.slave bus
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(LOCK_CNT + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    match_q, match_d;
  logic [WIDTH-1:0] ref_q, ref_d, expected;
  logic             legal;
  logic [IW-1:0]    index;
  logic             iv_d, wrap_d, cerr_d, serr_d;

  ring_onehot_decode #(.WIDTH(WIDTH)) u_decode (
    .code  (bus.Ring_in),
    .legal (legal),
    .index (index)
  );

  assign expected = WIDTH'(rotl(MAX_W'(ref_q), WIDTH));

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    ref_d   = ref_q;
    iv_d    = 1'b0;
    wrap_d  = 1'b0;
    cerr_d  = 1'b0;
    serr_d  = 1'b0;
    if (bus.Ring_valid) begin
      if (!legal) begin
        state_d = HUNT;
        match_d = '0;
        cerr_d  = 1'b1;
      end else begin
        ref_d = bus.Ring_in;
        iv_d  = 1'b1;
        unique case (state_q)
          HUNT: begin
            state_d = ACQUIRE;
            match_d = '0;
          end
          ACQUIRE: begin
            if (bus.Ring_in == expected) begin
              match_d = match_q + CW'(1);
              if (match_q + CW'(1) == CW'(LOCK_CNT)) state_d = LOCKED;
            end else begin
              match_d = '0;
              serr_d  = 1'b1;
            end
          end
          LOCKED: begin
            if (bus.Ring_in == expected) begin
              wrap_d = ref_q[WIDTH-1] & bus.Ring_in[0];
            end else begin
              state_d = ACQUIRE;
              match_d = '0;
              serr_d  = 1'b1;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q         <= HUNT;
      match_q         <= '0;
      ref_q           <= '0;
      bus.Index_out   <= '0;
      bus.Index_valid <= 1'b0;
      bus.Locked      <= 1'b0;
      bus.Wrap_pulse  <= 1'b0;
      bus.Code_err    <= 1'b0;
      bus.Seq_err     <= 1'b0;
      bus.Err_count   <= '0;
    end else begin
      state_q         <= state_d;
      match_q         <= match_d;
      ref_q           <= ref_d;
      bus.Index_valid <= iv_d;
      bus.Locked      <= (state_d == LOCKED);
      bus.Wrap_pulse  <= wrap_d;
      bus.Code_err    <= cerr_d;
      bus.Seq_err     <= serr_d;
      if (iv_d) bus.Index_out <= index;
      // Counter sticks at all ones until the next reset.
      if ((cerr_d || serr_d) && (bus.Err_count != '1))
        bus.Err_count <= bus.Err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ring_code_monitor.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// samples compared every cycle against a run-length model of the ring protocol.
module tb_ring_code_monitor;

  localparam int W  = 3;
  localparam int LC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ring_code_monitor_if #(.WIDTH(W), .ERR_CNT_W(8)) bus8 ();
  ring_code_monitor_if #(.WIDTH(W), .ERR_CNT_W(2)) bus2 ();

  ring_code_monitor #(.WIDTH(W), .LOCK_CNT(LC), .ERR_CNT_W(8)) dut8 (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus8.slave)
  );

  ring_code_monitor #(.WIDTH(W), .LOCK_CNT(LC), .ERR_CNT_W(2)) dut2 (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus2.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: chain = a legal code has been seen since the last illegal/reset,
  // run = consecutive in-order samples since the chain (re)started.
  bit m_chain;
  int m_last, m_run, m_errs;
  int m_idx, m_iv, m_lock, m_wrap, m_cerr, m_serr;

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_chain = 1'b0; m_last = 0; m_run = 0; m_errs = 0;
    m_idx = 0; m_iv = 0; m_lock = 0; m_wrap = 0; m_cerr = 0; m_serr = 0;
  endtask

  task automatic model_sample(bit v, logic [W-1:0] c);
    int idx;
    bit in_order;
    m_iv = 0; m_wrap = 0; m_cerr = 0; m_serr = 0;
    if (!v) return;
    if ($countones(c) != 1) begin
      m_cerr = 1; m_errs++; m_chain = 1'b0; m_run = 0;
    end else begin
      idx = $clog2(c);
      in_order = m_chain && (idx == (m_last + 1) % W);
      if (m_chain && !in_order) begin
        m_serr = 1; m_errs++; m_run = 0;
      end else if (in_order) begin
        m_wrap = (m_run >= LC) && (idx == 0);
        m_run++;
      end else begin
        m_run = 0;
      end
      m_chain = 1'b1; m_last = idx; m_idx = idx; m_iv = 1;
    end
    m_lock = (m_chain && m_run >= LC) ? 1 : 0;
  endtask

  task automatic step(bit r, bit v, logic [W-1:0] c);
    @(negedge clk);
    rst = r;
    bus8.Ring_valid = v; bus8.Ring_in = c;
    bus2.Ring_valid = v; bus2.Ring_in = c;
    @(posedge clk);
    if (r) model_reset(); else model_sample(v, c);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("index",    32'(bus8.Index_out),   m_idx);
      chk("ivalid",   32'(bus8.Index_valid), m_iv);
      chk("locked",   32'(bus8.Locked),      m_lock);
      chk("wrap",     32'(bus8.Wrap_pulse),  m_wrap);
      chk("code_err", 32'(bus8.Code_err),    m_cerr);
      chk("seq_err",  32'(bus8.Seq_err),     m_serr);
      chk("errcnt8",  32'(bus8.Err_count),   sat(m_errs, 255));
      chk("errcnt2",  32'(bus2.Err_count),   sat(m_errs, 3));
      chk("locked2",  32'(bus2.Locked),      m_lock);
    end
  end

  initial begin
    int exp6 [5] = '{1, 2, 3, 3, 3};
    logic [W-1:0] c;
    bit v, r;
    int sel;

    bus8.Ring_valid = 1'b0; bus8.Ring_in = '0;
    bus2.Ring_valid = 1'b0; bus2.Ring_in = '0;
    model_reset();

    step(1, 0, 3'b000);
    chk_en = 1'b1;
    chk("rst_index", 32'(bus8.Index_out), 0);
    chk("rst_locked", 32'(bus8.Locked), 0);
    chk("rst_errcnt", 32'(bus8.Err_count), 0);

    // Acquire and lock
    step(0, 1, 3'b001);
    chk("t1_idx0", 32'(bus8.Index_out), 0); chk("t1_iv0", 32'(bus8.Index_valid), 1);
    step(0, 1, 3'b010);
    chk("t1_idx1", 32'(bus8.Index_out), 1); chk("t1_lock_early", 32'(bus8.Locked), 0);
    step(0, 1, 3'b100);
    chk("t1_idx2", 32'(bus8.Index_out), 2); chk("t1_lock", 32'(bus8.Locked), 1);

    // Wrap
    step(0, 1, 3'b001);
    chk("t2_wrap", 32'(bus8.Wrap_pulse), 1); chk("t2_idx", 32'(bus8.Index_out), 0);
    chk("t2_lock", 32'(bus8.Locked), 1);     chk("t2_errs", 32'(bus8.Err_count), 0);

    // Illegal codes
    step(0, 1, 3'b011);
    chk("t3_cerr1", 32'(bus8.Code_err), 1); chk("t3_unlock", 32'(bus8.Locked), 0);
    step(0, 1, 3'b000);
    chk("t3_cerr2", 32'(bus8.Code_err), 1); chk("t3_errs", 32'(bus8.Err_count), 2);
    chk("t3_idx_hold", 32'(bus8.Index_out), 0);

    // Sequence error from LOCKED at 010, then relock
    step(0, 1, 3'b001); step(0, 1, 3'b010); step(0, 1, 3'b100);
    step(0, 1, 3'b001); step(0, 1, 3'b010);
    chk("t4_locked_at_010", 32'(bus8.Locked), 1);
    step(0, 1, 3'b001);
    chk("t4_serr", 32'(bus8.Seq_err), 1); chk("t4_unlock", 32'(bus8.Locked), 0);
    step(0, 1, 3'b010);
    step(0, 1, 3'b100);
    chk("t4_relock", 32'(bus8.Locked), 1); chk("t4_errs", 32'(bus8.Err_count), 3);

    // Idle gaps, then reset colliding with a valid sample
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'b001);
      chk("t5_idle_iv", 32'(bus8.Index_valid), 0); chk("t5_idle_idx", 32'(bus8.Index_out), 2);
    end
    step(0, 1, 3'b001);
    chk("t5_wrap", 32'(bus8.Wrap_pulse), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 3'b010);
    step(1, 1, 3'b001);
    chk("t5_rst_iv", 32'(bus8.Index_valid), 0); chk("t5_rst_errs", 32'(bus8.Err_count), 0);
    chk("t5_rst_lock", 32'(bus8.Locked), 0);

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 3'b111);
      chk("t6_errcnt2", 32'(bus2.Err_count), exp6[i]);
      chk("t6_cerr", 32'(bus2.Code_err), 1);
    end

    // Random phase; no resets in the second half so the 8-bit counter can saturate
    step(1, 0, 3'b000);
    for (int n = 0; n < 3000; n++) begin
      r = (n < 1500) && ($urandom_range(499) == 0);
      v = ($urandom_range(3) != 0);
      sel = $urandom_range(99);
      if (sel < 60)      c = W'(1 << ((m_last + 1) % W));
      else if (sel < 85) c = W'(1 << $urandom_range(W - 1));
      else               c = W'($urandom_range((1 << W) - 1));
      step(r, v, c);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
